// File: rtl/sram_bist_ctrl_if.sv
// SRAM macro port bundle: the controller drives commands and write data; the macro returns read data.
// No handshake: one access per clk, and read data returns a fixed RD_LAT cycles after the command.
interface sram_bist_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              s_clk;
  logic              s_cen;
  logic              s_wen;
  logic              s_oen;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_ddata;
  logic [DATA_W-1:0] s_qdata;

  modport master (
    output s_clk, s_cen, s_wen, s_oen, s_addr, s_ddata,
    input  s_qdata
  );

  modport slave (
    input  s_clk, s_cen, s_wen, s_oen, s_addr, s_ddata,
    output s_qdata
  );
endinterface

// File: rtl/sram_bist_ctrl.sv
// SRAM BIST sequencer: write / read-compare passes, one access per cycle, compare RD_LAT+1 cycles after issue.
// No backpressure (abort only); define FIRST_ERR_EN to build first-failure address/data capture.
module sram_bist_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_dir,
  input  logic              cfg_wrap,
  input  logic [ADDR_W-1:0] cfg_sta_addr,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [1:0]        cfg_pat_sel,
  input  logic [DATA_W-1:0] cfg_pat,
  output logic              busy,
  output logic              done,
  output logic [3:0]        state,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  sram_bist_ctrl_if.master  sram
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0000,
    ST_WRITE = 4'b0001,
    ST_READ  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  state_e            state_q, state_nxt;
  logic [ADDR_W-1:0] k_q, k_nxt;
  logic [2:0]        drain_q, drain_nxt;

  logic              wr_rd_q;
  logic              dir_q;
  logic [ADDR_W-1:0] sta_q;
  logic [ADDR_W-1:0] last_q;
  logic [1:0]        pat_sel_q;
  logic [DATA_W-1:0] pat_q;

  logic              cen_q, wen_q, oen_q;
  logic              cen_nxt, wen_nxt, oen_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] ddata_q, ddata_nxt;

  logic              start_acc;
  logic              rd_issue;
  logic              abort_hit;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_pat;
  logic [ADDR_W-1:0] lim_last;
  logic [ADDR_W-1:0] cfg_last;

  function automatic logic [DATA_W-1:0] pat_gen(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] seed,
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] k
  );
    logic [DATA_W-1:0] res;
    case (sel)
      2'd0:    res = seed;
      2'd1:    res = seed ^ DATA_W'(a);
      2'd2:    res = seed + DATA_W'(k);
      default: res = k[0] ? ~seed : seed;
    endcase
    return res;
  endfunction

  // Without wrap the last index is capped so the walk stops exactly at the array edge.
  assign lim_last = cfg_dir ? cfg_sta_addr : ~cfg_sta_addr;
  assign cfg_last = (!cfg_wrap && (cfg_len > lim_last)) ? lim_last : cfg_len;

  assign cur_addr = dir_q ? (sta_q - k_q) : (sta_q + k_q);
  assign cur_pat  = pat_gen(pat_sel_q, pat_q, cur_addr, k_q);

  assign abort_hit = cfg_abort &&
                     ((state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN));

  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    drain_nxt = drain_q;
    cen_nxt   = 1'b0;
    wen_nxt   = 1'b0;
    oen_nxt   = 1'b0;
    addr_nxt  = addr_q;
    ddata_nxt = ddata_q;
    start_acc = 1'b0;
    rd_issue  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          start_acc = 1'b1;
          k_nxt     = '0;
          state_nxt = (cfg_mode == 2'b01) ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
        end else begin
          cen_nxt   = 1'b1;
          wen_nxt   = 1'b1;
          addr_nxt  = cur_addr;
          ddata_nxt = cur_pat;
          if (k_q == last_q) begin
            k_nxt     = '0;
            state_nxt = wr_rd_q ? ST_READ : ST_DONE;
          end else begin
            k_nxt = k_q + ADDR_W'(1);
          end
        end
      end
      ST_READ: begin
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
        end else begin
          cen_nxt  = 1'b1;
          oen_nxt  = 1'b1;
          addr_nxt = cur_addr;
          rd_issue = 1'b1;
          if (k_q == last_q) begin
            drain_nxt = '0;
            state_nxt = ST_DRAIN;
          end else begin
            k_nxt = k_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
        end else if (drain_q == 3'(RD_LAT - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          drain_nxt = drain_q + 3'd1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      drain_q   <= '0;
      cen_q     <= 1'b0;
      wen_q     <= 1'b0;
      oen_q     <= 1'b0;
      addr_q    <= '0;
      ddata_q   <= '0;
      wr_rd_q   <= 1'b0;
      dir_q     <= 1'b0;
      sta_q     <= '0;
      last_q    <= '0;
      pat_sel_q <= '0;
      pat_q     <= '0;
    end else begin
      state_q <= state_nxt;
      k_q     <= k_nxt;
      drain_q <= drain_nxt;
      cen_q   <= cen_nxt;
      wen_q   <= wen_nxt;
      oen_q   <= oen_nxt;
      addr_q  <= addr_nxt;
      ddata_q <= ddata_nxt;
      if (start_acc) begin
        wr_rd_q   <= cfg_mode[1];
        dir_q     <= cfg_dir;
        sta_q     <= cfg_sta_addr;
        last_q    <= cfg_last;
        pat_sel_q <= cfg_pat_sel;
        pat_q     <= cfg_pat;
      end
    end
  end

  // Expected-data pipeline: stage RD_LAT lines up with s_qdata for the read issued RD_LAT+1 cycles earlier.
  logic [RD_LAT:0]   pv;
  logic [DATA_W-1:0] pd [RD_LAT+1];
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (reset || abort_hit) begin
      pv <= '0;
    end else begin
      pv <= {pv[RD_LAT-1:0], rd_issue};
    end
  end

  always_ff @(posedge clk) begin
    pd[0] <= cur_pat;
    for (int i = 1; i <= RD_LAT; i++) begin
      pd[i] <= pd[i-1];
    end
  end

  assign mismatch = pv[RD_LAT] && (sram.s_qdata != pd[RD_LAT]);

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

`ifdef FIRST_ERR_EN
  logic [ADDR_W-1:0] pa [RD_LAT+1];
  logic              first_seen;
  logic [ADDR_W-1:0] fa_q;
  logic [DATA_W-1:0] fd_q;

  always_ff @(posedge clk) begin
    pa[0] <= cur_addr;
    for (int i = 1; i <= RD_LAT; i++) begin
      pa[i] <= pa[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      first_seen <= 1'b0;
      fa_q       <= '0;
      fd_q       <= '0;
    end else if (mismatch && !first_seen) begin
      first_seen <= 1'b1;
      fa_q       <= pa[RD_LAT];
      fd_q       <= sram.s_qdata;
    end
  end

  assign first_err_addr = fa_q;
  assign first_err_data = fd_q;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

  assign busy  = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

  assign sram.s_clk   = clk;
  assign sram.s_cen   = cen_q;
  assign sram.s_wen   = wen_q;
  assign sram.s_oen   = oen_q;
  assign sram.s_addr  = addr_q;
  assign sram.s_ddata = ddata_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Scoreboard bench for sram_bist_ctrl: directed passes against a 1-cycle-latency SRAM model.
module tb_sram_bist_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_start = 1'b0;
  logic              cfg_abort = 1'b0;
  logic [1:0]        cfg_mode = '0;
  logic              cfg_dir = 1'b0;
  logic              cfg_wrap = 1'b0;
  logic [ADDR_W-1:0] cfg_sta_addr = '0;
  logic [ADDR_W-1:0] cfg_len = '0;
  logic [1:0]        cfg_pat_sel = '0;
  logic [DATA_W-1:0] cfg_pat = '0;
  logic              busy, done;
  logic [3:0]        state;
  logic [15:0]       err_cnt;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;

  sram_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  sram_bist_ctrl dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_mode(cfg_mode), .cfg_dir(cfg_dir), .cfg_wrap(cfg_wrap),
    .cfg_sta_addr(cfg_sta_addr), .cfg_len(cfg_len), .cfg_pat_sel(cfg_pat_sel),
    .cfg_pat(cfg_pat), .busy(busy), .done(done), .state(state), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data), .sram(sif)
  );

  always #5 clk = ~clk;

  // SRAM model with one cycle read latency; flip_en corrupts bit0 of reads from 0x005.
  logic [DATA_W-1:0] mem [1024];
  logic              flip_en = 1'b0;
  always @(posedge clk) begin
    if (sif.s_cen && sif.s_wen) mem[sif.s_addr] <= sif.s_ddata;
    if (sif.s_cen && sif.s_oen)
      sif.s_qdata <= mem[sif.s_addr] ^ ((flip_en && sif.s_addr == 10'h005) ? 8'h01 : 8'h00);
  end

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } acc_t;
  typedef struct { logic [15:0] e; logic [ADDR_W-1:0] fa; logic [DATA_W-1:0] fd; } res_t;
  acc_t              wq[$];
  logic [ADDR_W-1:0] rq[$];
  res_t              dq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    acc_t x;
    x.a = a; x.d = d;
    wq.push_back(x);
  endtask

  task automatic push_d(input logic [15:0] e, input logic [ADDR_W-1:0] fa, input logic [DATA_W-1:0] fd);
    res_t r;
    r.e = e;
`ifdef FIRST_ERR_EN
    r.fa = fa; r.fd = fd;
`else
    r.fa = '0; r.fd = '0;
    if (fa != fd) r.fa = '0;
`endif
    dq.push_back(r);
  endtask

  // Monitor: every bus access and done pulse is checked against the queues.
  res_t r_exp;
  logic res_pend = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (res_pend) begin
        res_pend = 1'b0;
        chk("err_cnt", 32'(err_cnt), 32'(r_exp.e));
        chk("first_err_addr", 32'(first_err_addr), 32'(r_exp.fa));
        chk("first_err_data", 32'(first_err_data), 32'(r_exp.fd));
      end
      if (sif.s_cen && sif.s_wen) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write addr=%0h data=%0h", sif.s_addr, sif.s_ddata);
        end else begin
          acc_t e;
          e = wq.pop_front();
          chk("wr_addr", 32'(sif.s_addr), 32'(e.a));
          chk("wr_data", 32'(sif.s_ddata), 32'(e.d));
        end
      end
      if (sif.s_cen && sif.s_oen) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read addr=%0h", sif.s_addr);
        end else begin
          chk("rd_addr", 32'(sif.s_addr), 32'(rq.pop_front()));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          r_exp = dq.pop_front();
          res_pend = 1'b1;
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic start_pass(input logic [1:0] mode, input logic dir, input logic wrap,
                            input logic [ADDR_W-1:0] sta, input logic [ADDR_W-1:0] len,
                            input logic [1:0] sel, input logic [DATA_W-1:0] pat);
    cfg_mode = mode; cfg_dir = dir; cfg_wrap = wrap; cfg_sta_addr = sta;
    cfg_len = len; cfg_pat_sel = sel; cfg_pat = pat; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cen", 32'(sif.s_cen), 32'd0);
    chk("rst_wen", 32'(sif.s_wen), 32'd0);
    chk("rst_oen", 32'(sif.s_oen), 32'd0);
    chk("rst_addr", 32'(sif.s_addr), 32'd0);
    chk("rst_ddata", 32'(sif.s_ddata), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_first_addr", 32'(first_err_addr), 32'd0);
    chk("rst_first_data", 32'(first_err_data), 32'd0);

    // Write-then-verify with wrap across the top of the array.
    push_w(10'h3FE, 8'hA5); push_w(10'h3FF, 8'hA5); push_w(10'h000, 8'hA5); push_w(10'h001, 8'hA5);
    rq.push_back(10'h3FE); rq.push_back(10'h3FF); rq.push_back(10'h000); rq.push_back(10'h001);
    push_d(16'd0, '0, '0);
    start_pass(2'b10, 1'b0, 1'b1, 10'h3FE, 10'd3, 2'd0, 8'hA5);
    wait_done("wrap_pass");

    // Same pass clipped at the array edge.
    push_w(10'h3FE, 8'hA5); push_w(10'h3FF, 8'hA5);
    rq.push_back(10'h3FE); rq.push_back(10'h3FF);
    push_d(16'd0, '0, '0);
    start_pass(2'b10, 1'b0, 1'b0, 10'h3FE, 10'd3, 2'd0, 8'hA5);
    wait_done("clip_pass");

    // Decrementing write-only with incrementing pattern.
    push_w(10'h001, 8'h10); push_w(10'h000, 8'h11); push_w(10'h3FF, 8'h12);
    push_d(16'd0, '0, '0);
    start_pass(2'b00, 1'b1, 1'b1, 10'h001, 10'd2, 2'd2, 8'h10);
    wait_done("dec_pass");

    // Alternating pattern with a stuck bit at 0x005.
    flip_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      push_w(10'(k), (k % 2 == 1) ? 8'hAA : 8'h55);
      rq.push_back(10'(k));
    end
    push_d(16'd1, 10'h005, 8'hAB);
    start_pass(2'b10, 1'b0, 1'b1, 10'h000, 10'd15, 2'd3, 8'h55);
    wait_done("err_pass");
    flip_en = 1'b0;

    // Abort on the third write cycle; a start pulsed while busy must be ignored.
    push_w(10'h000, 8'h3C); push_w(10'h001, 8'h3C);
    start_pass(2'b00, 1'b0, 1'b1, 10'h000, 10'd9, 2'd0, 8'h3C);
    cfg_sta_addr = 10'h200; cfg_mode = 2'b01; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cen", 32'(sif.s_cen), 32'd0);
    chk("abort_wen", 32'(sif.s_wen), 32'd0);
    chk("abort_err_cleared", 32'(err_cnt), 32'd0);
    repeat (12) @(negedge clk);

    // Read-only pass, address-XOR pattern, clipped: 0x3FE holds A5, 0x3FF holds 12.
    rq.push_back(10'h3FE); rq.push_back(10'h3FF);
    push_d(16'd2, 10'h3FE, 8'hA5);
    start_pass(2'b01, 1'b0, 1'b0, 10'h3FE, 10'd5, 2'd1, 8'h0F);
    wait_done("read_pass");

    repeat (3) @(negedge clk);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
